// File: rtl/pimt_pkg.sv
// rtl/pimt_pkg.sv - shared constants and entry type for the pimt result path
package pimt_pkg;

    localparam int FP64_W = 64;
    localparam logic [FP64_W-1:0] FP64_SCALE_64 = 64'h4050000000000000;
    localparam int FRAME_CNT_W = 16;

    typedef struct packed {
        logic              last;
        logic [FP64_W-1:0] data;
    } pimt_entry_t;

endpackage

// File: rtl/pimt6_collect_if.sv
// rtl/pimt6_collect_if.sv - result input and buffered output stream bundle
interface pimt6_collect_if;
    import pimt_pkg::*;

    logic [FP64_W-1:0] in_data;
    logic              in_vld;
    logic [FP64_W-1:0] m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;

    modport master (
        output in_data, in_vld, m_tready,
        input  m_tdata, m_tvalid, m_tlast
    );

    modport slave (
        input  in_data, in_vld, m_tready,
        output m_tdata, m_tvalid, m_tlast
    );
endinterface

// File: rtl/pimt_fifo.sv
// rtl/pimt_fifo.sv - synchronous first-word-fall-through FIFO
module pimt_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Empty FIFO shows zero rather than stale memory contents
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/pimt6_collect.sv
// rtl/pimt6_collect.sv - buffers pimt6 results into a framed valid/ready stream
module pimt6_collect
    import pimt_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int FRAME_LEN = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    pimt6_collect_if.slave         bus,
    input  logic                   clr_ovf,
    output logic [$clog2(DEPTH):0] fill_level,
    output logic                   frame_done,
    output logic                   overflow,
    output logic [15:0]            drop_cnt
);
    localparam logic [FRAME_CNT_W-1:0] LAST_POS = FRAME_CNT_W'(FRAME_LEN - 1);

    pimt_entry_t            wr_entry, rd_entry;
    logic                   fifo_full, fifo_empty;
    logic                   push, pop, drop, at_last;
    logic [FRAME_CNT_W-1:0] frame_pos_q, frame_pos_d;
    logic                   frame_done_q, frame_done_d;
    logic                   overflow_q, overflow_d;
    logic [15:0]            drop_cnt_q, drop_cnt_d;

    // The upstream pipeline cannot stall, so a full FIFO only accepts when it pops
    assign pop     = !fifo_empty && bus.m_tready;
    assign push    = bus.in_vld && (!fifo_full || pop);
    assign drop    = bus.in_vld && fifo_full && !pop;
    assign at_last = (frame_pos_q == LAST_POS);

    assign wr_entry.last = at_last;
    assign wr_entry.data = bus.in_data;

    pimt_fifo #(
        .WIDTH ($bits(pimt_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (wr_entry),
        .dout  (rd_entry),
        .count (fill_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.m_tdata  = rd_entry.data;
    assign bus.m_tlast  = rd_entry.last;
    assign bus.m_tvalid = !fifo_empty;

    always_comb begin
        frame_pos_d  = frame_pos_q;
        frame_done_d = bus.in_vld && at_last;
        overflow_d   = overflow_q;
        drop_cnt_d   = drop_cnt_q;
        if (bus.in_vld) begin
            frame_pos_d = at_last ? '0 : frame_pos_q + FRAME_CNT_W'(1);
        end
        // A drop in the same cycle as a clear overrides the clear
        if (clr_ovf) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (clr_ovf) begin
                drop_cnt_d = 16'd1;
            end else if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_pos_q  <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            frame_pos_q  <= frame_pos_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign drop_cnt   = drop_cnt_q;
endmodule
